// File: rtl/x_oddr2_ser.sv
// Output DDR serializer: accepts WIDTH-bit words over valid/ready and emits
// two bits per enabled cycle as a (Q0, Q1) pair for an output DDR primitive.
// A holding register in front of the shifter lets words run back-to-back.
module x_oddr2_ser #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter logic        INIT_Q0   = 1'b0,
  parameter logic        INIT_Q1   = 1'b0,
  parameter bit          IDLE_HOLD = 1'b0
) (
  input  logic             C,
  input  logic             RN,
  input  logic             CE,
  input  logic [WIDTH-1:0] DIN,
  input  logic             DIN_VALID,
  output logic             DIN_READY,
  output logic             Q0,
  output logic             Q1,
  output logic             Q_VALID,
  output logic             BUSY
);

  localparam int unsigned Beats = WIDTH / 2;
  localparam int unsigned BeatW = (Beats > 1) ? $clog2(Beats) : 1;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(Beats - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_hold, w_hold_nxt;
  logic               r_hold_valid, w_hold_valid_nxt;
  logic [WIDTH-1:0]   r_shift, w_shift_nxt;
  logic [BeatW-1:0]   r_beat, w_beat_nxt;
  logic               r_q0, w_q0_nxt;
  logic               r_q1, w_q1_nxt;
  logic               r_q_valid, w_q_valid_nxt;
  logic               r_busy, w_busy_nxt;

  logic               w_accept;
  logic               w_load;
  logic               w_adv;
  logic [WIDTH-1:0]   w_src;

  // Ready looks only at the holding register, so a full hold refuses a word
  // even in the cycle it drains into the shifter.
  assign DIN_READY = CE & ~r_hold_valid;
  assign w_accept  = CE & DIN_VALID & ~r_hold_valid;

  // Next-state: decide load/advance/idle, then derive the emitted pair.
  always_comb begin
    w_state_nxt      = r_state;
    w_hold_nxt       = r_hold;
    w_hold_valid_nxt = r_hold_valid;
    w_shift_nxt      = r_shift;
    w_beat_nxt       = r_beat;
    w_q0_nxt         = r_q0;
    w_q1_nxt         = r_q1;
    w_q_valid_nxt    = r_q_valid;
    w_busy_nxt       = r_busy;
    w_load           = 1'b0;
    w_adv            = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (r_hold_valid) w_load = 1'b1;
      end
      StShift: begin
        if (r_beat == LastBeat) begin
          if (r_hold_valid) w_load = 1'b1;
        end else begin
          w_adv = 1'b1;
        end
      end
      default: ;
    endcase

    // The shifter always keeps the next pair at the same end of the word.
    w_src = w_load ? r_hold : r_shift;

    if (w_load || w_adv) begin
      if (MSB_FIRST) begin
        w_q0_nxt    = w_src[WIDTH-1];
        w_q1_nxt    = w_src[WIDTH-2];
        w_shift_nxt = w_src << 2;
      end else begin
        w_q0_nxt    = w_src[0];
        w_q1_nxt    = w_src[1];
        w_shift_nxt = w_src >> 2;
      end
      w_beat_nxt    = w_load ? '0 : r_beat + BeatW'(1);
      w_state_nxt   = StShift;
      w_q_valid_nxt = 1'b1;
    end else begin
      w_state_nxt   = StIdle;
      w_q_valid_nxt = 1'b0;
      w_beat_nxt    = '0;
      if (!IDLE_HOLD) begin
        w_q0_nxt = INIT_Q0;
        w_q1_nxt = INIT_Q1;
      end
    end

    // Load and accept are exclusive: load needs a full hold, accept an empty one.
    if (w_load) w_hold_valid_nxt = 1'b0;
    if (w_accept) begin
      w_hold_valid_nxt = 1'b1;
      w_hold_nxt       = DIN;
    end

    w_busy_nxt = (w_state_nxt == StShift) | w_hold_valid_nxt;
  end

  // State registers: synchronous reset wins over the clock enable.
  always_ff @(posedge C) begin
    if (!RN) begin
      r_state      <= StIdle;
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_shift      <= '0;
      r_beat       <= '0;
      r_q0         <= INIT_Q0;
      r_q1         <= INIT_Q1;
      r_q_valid    <= 1'b0;
      r_busy       <= 1'b0;
    end else if (CE) begin
      r_state      <= w_state_nxt;
      r_hold       <= w_hold_nxt;
      r_hold_valid <= w_hold_valid_nxt;
      r_shift      <= w_shift_nxt;
      r_beat       <= w_beat_nxt;
      r_q0         <= w_q0_nxt;
      r_q1         <= w_q1_nxt;
      r_q_valid    <= w_q_valid_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  assign Q0      = r_q0;
  assign Q1      = r_q1;
  assign Q_VALID = r_q_valid;
  assign BUSY    = r_busy;

endmodule

// File: tb/tb_x_oddr2_ser.sv
// Bench for x_oddr2_ser: an MSB-first instance and an LSB-first/idle-hold
// instance share one input stream and are checked against a queue model.
module tb_x_oddr2_ser;

  logic       C;
  logic       RN;
  logic       CE;
  logic [7:0] DIN;
  logic       DIN_VALID;
  logic       rdy_m, q0_m, q1_m, qv_m, busy_m;
  logic       rdy_l, q0_l, q1_l, qv_l, busy_l;

  int unsigned n_checks;
  int unsigned n_errors;

  // Model state: one shared holding slot plus a pending-beat queue per instance.
  logic       m_hold_full;
  logic [7:0] m_hold_word;
  logic [1:0] bq_m[$];
  logic [1:0] bq_l[$];
  logic       e_q0_m, e_q1_m, e_q0_l, e_q1_l, e_qv, e_busy;
  logic       m_acc;

  x_oddr2_ser #(
    .WIDTH(8), .MSB_FIRST(1'b1), .INIT_Q0(1'b0), .INIT_Q1(1'b0), .IDLE_HOLD(1'b0)
  ) u_msb (
    .C(C), .RN(RN), .CE(CE), .DIN(DIN), .DIN_VALID(DIN_VALID), .DIN_READY(rdy_m),
    .Q0(q0_m), .Q1(q1_m), .Q_VALID(qv_m), .BUSY(busy_m)
  );

  x_oddr2_ser #(
    .WIDTH(8), .MSB_FIRST(1'b0), .INIT_Q0(1'b1), .INIT_Q1(1'b0), .IDLE_HOLD(1'b1)
  ) u_lsb (
    .C(C), .RN(RN), .CE(CE), .DIN(DIN), .DIN_VALID(DIN_VALID), .DIN_READY(rdy_l),
    .Q0(q0_l), .Q1(q1_l), .Q_VALID(qv_l), .BUSY(busy_l)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One enabled edge of the reference: finish the current word, else start the
  // held word, else idle; then take a new word into the slot if it was free.
  task automatic model_edge(input logic rn, input logic ce, input logic valid,
                            input logic [7:0] din);
    logic [1:0] pm, pl;
    logic       emitted;
    m_acc = 1'b0;
    if (!rn) begin
      m_hold_full = 1'b0;
      bq_m.delete();
      bq_l.delete();
      e_q0_m = 1'b0; e_q1_m = 1'b0;
      e_q0_l = 1'b1; e_q1_l = 1'b0;
      e_qv = 1'b0; e_busy = 1'b0;
    end else if (ce) begin
      m_acc = valid && !m_hold_full;
      emitted = 1'b0;
      if (bq_m.size() == 0 && m_hold_full) begin
        for (int k = 0; k < 4; k++) begin
          bq_m.push_back({m_hold_word[7-2*k], m_hold_word[6-2*k]});
          bq_l.push_back({m_hold_word[2*k], m_hold_word[2*k+1]});
        end
        m_hold_full = 1'b0;
      end
      if (bq_m.size() != 0) begin
        pm = bq_m.pop_front();
        pl = bq_l.pop_front();
        e_q0_m = pm[1]; e_q1_m = pm[0];
        e_q0_l = pl[1]; e_q1_l = pl[0];
        emitted = 1'b1;
      end else begin
        e_q0_m = 1'b0; e_q1_m = 1'b0;
      end
      e_qv = emitted;
      if (m_acc) begin
        m_hold_full = 1'b1;
        m_hold_word = din;
      end
      e_busy = emitted | m_hold_full;
    end
  endtask

  task automatic step(input logic rn, input logic ce, input logic valid,
                      input logic [7:0] din);
    RN = rn; CE = ce; DIN_VALID = valid; DIN = din;
    #1;
    chk("ready_m", rdy_m, ce & ~m_hold_full);
    chk("ready_l", rdy_l, ce & ~m_hold_full);
    @(posedge C);
    model_edge(rn, ce, valid, din);
    #1;
    chk("pair_m", {q0_m, q1_m}, {e_q0_m, e_q1_m});
    chk("pair_l", {q0_l, q1_l}, {e_q0_l, e_q1_l});
    chk("qvalid_m", qv_m, e_qv);
    chk("qvalid_l", qv_l, e_qv);
    chk("busy_m", busy_m, e_busy);
    chk("busy_l", busy_l, e_busy);
  endtask

  task automatic send_word(input logic [7:0] w);
    int n;
    n = 0;
    do begin
      step(1'b1, 1'b1, 1'b1, w);
      n++;
    end while (!m_acc && n < 40);
    chk("send_accepted", m_acc, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 8'h00);
  endtask

  logic [1:0] exp_b4_m[4];
  logic [1:0] exp_b4_l[4];

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_hold_full = 1'b0;
    m_hold_word = 8'h00;
    e_q0_m = 1'b0; e_q1_m = 1'b0; e_q0_l = 1'b1; e_q1_l = 1'b0;
    e_qv = 1'b0; e_busy = 1'b0; m_acc = 1'b0;
    RN = 1'b0; CE = 1'b1; DIN_VALID = 1'b0; DIN = 8'h00;
    exp_b4_m = '{2'b10, 2'b11, 2'b01, 2'b00};
    exp_b4_l = '{2'b00, 2'b10, 2'b11, 2'b01};

    // Reset held with a word offered: nothing may be taken.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 8'hFF);
    chk("reset_q_m", {q0_m, q1_m, qv_m, busy_m}, 4'b0000);
    chk("reset_q_l", {q0_l, q1_l, qv_l, busy_l}, 4'b1000);
    idle(1);

    // Single word 0xB4 with literal pair expectations.
    step(1'b1, 1'b1, 1'b1, 8'hB4);
    chk("b4_accept", m_acc, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1, 1'b0, 8'h00);
      chk("b4_pair_m", {q0_m, q1_m}, exp_b4_m[k]);
      chk("b4_pair_l", {q0_l, q1_l}, exp_b4_l[k]);
      chk("b4_qvalid", qv_m, 1'b1);
    end
    step(1'b1, 1'b1, 1'b0, 8'h00);
    chk("b4_idle_m", {q0_m, q1_m, qv_m}, 3'b000);
    chk("b4_idle_hold_l", {q0_l, q1_l, qv_l}, 3'b010);

    // Back-to-back words, then three words under backpressure.
    send_word(8'hA5);
    send_word(8'h3C);
    idle(10);
    send_word(8'h11);
    send_word(8'h22);
    send_word(8'h33);
    idle(12);

    // CE dropped for three cycles after beat 1.
    send_word(8'hB4);
    idle(2);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b1, 8'h5A);
      chk("ce_hold_m", {q0_m, q1_m, qv_m}, 3'b111);
    end
    idle(6);

    // Reset mid-word with a second word waiting in the holding register.
    send_word(8'hB4);
    send_word(8'h96);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("midreset_busy", busy_m, 1'b0);
    idle(6);

    // Randomized traffic with occasional CE drops and resets.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 2) != 0), 8'($urandom));
    end
    idle(10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
